// File: rtl/mem_pkg.sv
// Purpose: shared definitions for the memory access stage: access size
//          encodings, FSM state enum, latency counter sizing, latched
//          access payload and alignment helpers.
// Optional feature macro used by consumers: MEM_ALIGN_CHECK_EN.
package mem_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned MEM_LATENCY_MAX = 7;
  localparam int unsigned CNT_W           = 3;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Request fields captured at accept and held for the whole access.
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sign;
    logic [1:0]        lo;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  // Reserved size encoding behaves as a full word.
  function automatic logic is_word(input logic [1:0] size);
    return (size != SZ_HALF) && (size != SZ_BYTE);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Purpose: combinational byte/half lane handling for the memory stage.
//   Load path extracts the addressed lane from the read word and sign- or
//   zero-extends it; store path merges the low store bytes into the read word.
// Ports:
//   size         in  2   access size (SZ_WORD/SZ_HALF/SZ_BYTE, reserved = word)
//   sign         in  1   1 sign-extend loads, 0 zero-extend
//   lane         in  2   byte address low bits (half uses lane[1] only)
//   rword        in  32  word read from memory
//   wdata        in  32  store data, low byte/half used for sub-word stores
//   load_data_c  out 32  extracted load value
//   store_word_c out 32  read word with the addressed lane(s) replaced
module mem_lane_ext
  import mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rword,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] store_word_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane pick, little-endian: lane 0 is bits [7:0].
  always_comb begin
    byte_c = rword[7:0];
    case (lane)
      2'd0:    byte_c = rword[7:0];
      2'd1:    byte_c = rword[15:8];
      2'd2:    byte_c = rword[23:16];
      default: byte_c = rword[31:24];
    endcase
    half_c = lane[1] ? rword[31:16] : rword[15:0];
  end

  // Load extraction.
  always_comb begin
    load_data_c = rword;
    case (size)
      SZ_BYTE: load_data_c = {{24{sign & byte_c[7]}}, byte_c};
      SZ_HALF: load_data_c = {{16{sign & half_c[15]}}, half_c};
      default: load_data_c = rword;
    endcase
  end

  // Store merge for read-modify-write.
  always_comb begin
    store_word_c = rword;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    store_word_c[7:0]   = wdata[7:0];
          2'd1:    store_word_c[15:8]  = wdata[7:0];
          2'd2:    store_word_c[23:16] = wdata[7:0];
          default: store_word_c[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) store_word_c[31:16] = wdata[15:0];
        else         store_word_c[15:0]  = wdata[15:0];
      end
      default: store_word_c = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: memory-side stage after the address mux. Drives a word-addressed
//   synchronous memory and performs lw/lh/lb loads and sw/sh/sb stores;
//   sub-word stores use read-modify-write. req/busy/done handshake.
// Parameter: MEM_LATENCY (1..7) cycles from mem_addr stable to mem_rdata valid.
// Optional feature: define MEM_ALIGN_CHECK_EN to add the misalign output;
//   misaligned half/word accesses then skip memory and complete immediately.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req, we, size     access request, store flag, access size
//   sign, addr, wdata load extension, byte address, store data
//   rdata             extracted load result, held until next load completes
//   busy, done        in-progress flag, single-cycle completion pulse
//   mem_addr, mem_wr  word address to memory, write strobe
//   mem_wdata         word written to memory
//   mem_rdata         word read from memory
//   misalign          (MEM_ALIGN_CHECK_EN only) misaligned access flag
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_wr_q, mem_wr_d;
  logic              misalign_c;
  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] store_word_c;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign_c = is_misaligned(size, addr[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  // Lane logic always works on the latched request and the live read word.
  mem_lane_ext u_lane_ext (
    .size         (acc_q.size),
    .sign         (acc_q.sign),
    .lane         (acc_q.lo),
    .rword        (mem_rdata),
    .wdata        (acc_q.wdata),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_wr_d    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          acc_d      = '{we: we, size: size, sign: sign, lo: addr[1:0], wdata: wdata};
          mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
          busy_d     = 1'b1;
          if (misalign_c) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else if (we && is_word(size)) begin
            // Full-word store needs no read.
            state_d     = ST_WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = wdata;
          end else begin
            state_d = ST_READ;
            cnt_d   = CNT_START;
          end
        end
      end

      ST_READ: begin
        if (cnt_q == '0) begin
          if (acc_q.we) begin
            state_d     = ST_WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = store_word_c;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            rdata_d = load_data_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end

      ST_DONE: begin
        // req here is ignored; earliest new accept is next cycle in IDLE.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_wr_q    <= mem_wr_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural word memory, reference model for
// load extraction and store merging, expected completions queued per access.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int unsigned LAT = 1;
  localparam int unsigned P   = LAT + 2;

  logic        clk = 1'b0;
  logic        reset, req, we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, mem_wr;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  // Memory: data always available for the current address; bench preload
  // and DUT writes share one process.
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  assign mem_rdata = mem[6'(mem_addr >> 2)];
  always @(posedge clk) begin
    if (pre_en)      mem[pre_idx] <= pre_val;
    else if (mem_wr) mem[6'(mem_addr >> 2)] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] addr_w;
    logic [31:0] wr_data;
    logic [31:0] rdata;
    int          wr_cyc;
    int          done_cyc;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_mem [0:63];
  logic [31:0] exp_rdata = '0;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] lo);
    logic [31:0] sh;
    if (sz == SZ_BYTE) begin
      sh = w >> (8 * lo);
      return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    end else if (sz == SZ_HALF) begin
      sh = w >> (lo[1] ? 16 : 0);
      return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    end
    return w;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] m, v;
    if (sz == SZ_BYTE) begin
      m = 32'h0000_00FF << (8 * lo);
      v = (d & 32'h0000_00FF) << (8 * lo);
    end else begin
      m = 32'h0000_FFFF << (lo[1] ? 16 : 0);
      v = (d & 32'h0000_FFFF) << (lo[1] ? 16 : 0);
    end
    return (w & ~m) | (v & m);
  endfunction

  task automatic init_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 6'(idx); pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
    exp_mem[idx] = val;
  endtask

  // One access: model expectation queued, then observed cycle by cycle.
  task automatic do_access(input string nm, input logic w, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
    exp_t e, got;
    int   idx, wr_seen;
    bit   seen_done;
    logic [31:0] word;
    idx  = int'(a[7:2]);
    word = exp_mem[idx];
    e.addr_w = {a[31:2], 2'b00};
    e.wr_cyc = -1; e.wr_data = '0; e.mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    e.mis = ((sz == SZ_HALF) && a[0]) || ((sz != SZ_HALF) && (sz != SZ_BYTE) && (a[1:0] != 2'b00));
`endif
    if (e.mis) begin
      e.done_cyc = 1;
    end else if (!w) begin
      exp_rdata  = model_load(word, sz, sg, a[1:0]);
      e.done_cyc = 1 + LAT;
    end else if (sz == SZ_HALF || sz == SZ_BYTE) begin
      e.wr_cyc   = 1 + LAT;
      e.wr_data  = model_merge(word, wd, sz, a[1:0]);
      e.done_cyc = 2 + LAT;
    end else begin
      e.wr_cyc   = 1;
      e.wr_data  = wd;
      e.done_cyc = 2;
    end
    if (e.wr_cyc > 0) exp_mem[idx] = e.wr_data;
    e.rdata = exp_rdata;
    exp_q.push_back(e);

    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; we = ~w; addr = ~a; wdata = ~wd;
    wr_seen = 0; seen_done = 0;
    got = e;
    for (int c = 1; c <= 20 && !seen_done; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1) $display("FAIL %s busy c%0d: got %b want 1", nm, c, busy);
      else passes++;
      if (mem_wr === 1'b1) begin
        wr_seen++;
        checks++;
        if (c != e.wr_cyc || mem_wdata !== e.wr_data || mem_addr !== e.addr_w)
          $display("FAIL %s write: cyc %0d data %h addr %h want cyc %0d data %h addr %h",
                   nm, c, mem_wdata, mem_addr, e.wr_cyc, e.wr_data, e.addr_w);
        else passes++;
      end
      if (done === 1'b1) begin
        seen_done = 1;
        got = exp_q.pop_front();
        checks++;
        if (c != got.done_cyc) $display("FAIL %s done_cycle: got %0d want %0d", nm, c, got.done_cyc);
        else passes++;
        checks++;
        if (rdata !== got.rdata) $display("FAIL %s rdata: got %h want %h", nm, rdata, got.rdata);
        else passes++;
        checks++;
        if (mem_addr !== got.addr_w) $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, got.addr_w);
        else passes++;
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (misalign !== got.mis) $display("FAIL %s misalign: got %b want %b", nm, misalign, got.mis);
        else passes++;
`endif
      end
    end
    if (!seen_done) begin
      checks++;
      $display("FAIL %s done_timeout: got none want done by cycle %0d", nm, e.done_cyc);
      got = exp_q.pop_front();
    end
    checks++;
    if (wr_seen != ((got.wr_cyc > 0) ? 1 : 0))
      $display("FAIL %s write_count: got %0d want %0d", nm, wr_seen, (got.wr_cyc > 0) ? 1 : 0);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s after_done: busy %b done %b want 0 0", nm, busy, done);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rdata !== '0 || busy !== 1'b0 || done !== 1'b0 || mem_wr !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_values: rdata %h busy %b done %b wr %b addr %h wdata %h want all 0",
               rdata, busy, done, mem_wr, mem_addr, mem_wdata);
    else passes++;
    reset = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_load();
    init_word(4, 32'h8899_AABB);
    do_access("lw",      1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0);
    do_access("lb_s",    1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0);
    do_access("lb_u",    1'b0, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0);
    do_access("lb1_s",   1'b0, SZ_BYTE, 1'b1, 32'h0000_0011, 32'h0);
    do_access("lh_hi_s", 1'b0, SZ_HALF, 1'b1, 32'h0000_0012, 32'h0);
    do_access("lh_lo_u", 1'b0, SZ_HALF, 1'b0, 32'h0000_0010, 32'h0);
    do_access("lw_rsvd", 1'b0, SZ_RSVD, 1'b1, 32'h0000_0010, 32'h0);
  endtask

  task automatic test_store();
    init_word(8, 32'h1122_3344);
    do_access("sb",      1'b1, SZ_BYTE, 1'b0, 32'h0000_0021, 32'h0000_00CC);
    init_word(8, 32'h1122_3344);
    do_access("sh",      1'b1, SZ_HALF, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF);
    do_access("sw",      1'b1, SZ_WORD, 1'b0, 32'h0000_0030, 32'hCAFE_F00D);
    do_access("lw_back", 1'b0, SZ_WORD, 1'b0, 32'h0000_0030, 32'h0);
    do_access("sb3",     1'b1, SZ_BYTE, 1'b0, 32'h0000_0033, 32'h1234_5677);
    do_access("lw_sb3",  1'b0, SZ_WORD, 1'b0, 32'h0000_0030, 32'h0);
  endtask

  task automatic test_reset_mid_access();
    int bad;
    init_word(8, 32'h1122_3344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = SZ_HALF; sign = 1'b0; addr = 32'h0000_0022; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL rst_mid busy_before: got %b want 1", busy);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rdata !== '0 || busy !== 1'b0 || done !== 1'b0 || mem_wr !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL rst_mid values: rdata %h busy %b done %b wr %b addr %h wdata %h want all 0",
               rdata, busy, done, mem_wr, mem_addr, mem_wdata);
    else passes++;
    reset = 1'b0;
    exp_rdata = '0;
    bad = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done !== 1'b0 || mem_wr !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL rst_mid late_activity: got %0d cycles want 0", bad);
    else passes++;
    checks++;
    if (mem[8] !== 32'h1122_3344) $display("FAIL rst_mid memory: got %h want %h", mem[8], 32'h1122_3344);
    else passes++;
  endtask

  // req held high: a new access is accepted only in IDLE, every P cycles.
  task automatic test_back_to_back();
    logic e_done, e_busy;
    int   dones;
    dones = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = SZ_WORD; sign = 1'b0; addr = 32'h0000_0010; wdata = '0;
    exp_rdata = 32'h8899_AABB;
    for (int c = 1; c <= 3 * int'(P); c++) begin
      @(negedge clk);
      e_done = ((c % int'(P)) == int'(P) - 1);
      e_busy = ((c % int'(P)) != 0);
      if (done === 1'b1) dones++;
      checks++;
      if (done !== e_done || busy !== e_busy || mem_wr !== 1'b0)
        $display("FAIL b2b c%0d: done %b busy %b wr %b want %b %b 0", c, done, busy, mem_wr, e_done, e_busy);
      else passes++;
    end
    req = 1'b0;
    checks++;
    if (dones != 3) $display("FAIL b2b done_count: got %0d want 3", dones);
    else passes++;
    checks++;
    if (rdata !== exp_rdata) $display("FAIL b2b rdata: got %h want %h", rdata, exp_rdata);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b idle_after: got busy %b want 0", busy);
    else passes++;
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    init_word(1, 32'h5555_AAAA);
    do_access("lw_mis",  1'b0, SZ_WORD, 1'b0, 32'h0000_0006, 32'h0);
    do_access("sh_mis",  1'b1, SZ_HALF, 1'b0, 32'h0000_0023, 32'hFFFF_0000);
    do_access("sb_odd",  1'b1, SZ_BYTE, 1'b0, 32'h0000_0005, 32'h0000_0011);
    do_access("lw_ok",   1'b0, SZ_WORD, 1'b0, 32'h0000_0004, 32'h0);
  endtask
`endif

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = SZ_WORD; sign = 1'b0;
    addr = '0; wdata = '0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
    test_reset();
    for (int i = 0; i < 64; i++) init_word(i, 32'h0);
    test_load();
    test_store();
    test_reset_mid_access();
    test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
